// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver
// Receiving end of a VGA timing stream. It registers hsync/vsync/rgb, recovers
// pixel coordinates and a data-valid strobe, measures line and frame lengths,
// and checks them against the configured mode to report lock.
//
// Output strobe semantics: pix_valid is a pure valid strobe with no ready
// (no backpressure). When pix_valid=1, pix_x/pix_y/pix_rgb describe one active
// pixel for exactly that cycle. When pix_valid=0, all three are 0.
// An rgb value sampled at the input on cycle n appears on pix_rgb on cycle n+2,
// together with its coordinates.
module vga_sync_receiver #(
  parameter int h_size      = 800,
  parameter int h_synctime  = 80,
  parameter int h_porch     = 80,
  parameter int v_size      = 600,
  parameter int v_synctime  = 1,
  parameter int v_porch     = 46,
  parameter int lock_frames = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_valid,
  output logic [2:0]  pix_rgb,
  output logic [11:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        timing_err,
  output logic [1:0]  state_dbg
);

  localparam logic [11:0] h_period    = 12'(h_size + h_synctime + h_porch);
  localparam logic [11:0] h_start     = 12'(h_synctime + h_porch);
  localparam logic [10:0] h_start_x   = h_start[10:0];
  localparam logic [10:0] v_period    = 11'(v_size + v_synctime + v_porch);
  localparam logic [10:0] v_start     = 11'(v_synctime + v_porch);
  localparam logic [9:0]  v_start_y   = v_start[9:0];
  localparam logic [3:0]  lock_target = 4'(lock_frames);

  localparam logic [1:0] st_search = 2'd0;
  localparam logic [1:0] st_track  = 2'd1;
  localparam logic [1:0] st_locked = 2'd2;

  logic        hs_q, hs_d, vs_q, vs_d;
  logic [2:0]  rgb_q;
  logic [11:0] h_cnt, h_inc, h_next;
  logic [10:0] v_cnt, v_inc, v_next;
  logic [3:0]  good_cnt, good_inc;
  logic [1:0]  state;
  logic        hs_rise, vs_rise;
  logic        active, line_err, frame_err, err;

  assign state_dbg = state;

  // Stage 1: sample the incoming sync and colour, keep the previous sync sample for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q  <= 1'b0;
      hs_d  <= 1'b0;
      vs_q  <= 1'b0;
      vs_d  <= 1'b0;
      rgb_q <= 3'd0;
    end else begin
      hs_q  <= hsync;
      hs_d  <= hs_q;
      vs_q  <= vsync;
      vs_d  <= vs_q;
      rgb_q <= rgb;
    end
  end

  // Counter advance, active-region decode and timing checks for the stage-1 sample
  always_comb begin
    hs_rise  = hs_q & ~hs_d;
    vs_rise  = vs_q & ~vs_d;
    h_inc    = (h_cnt == 12'hfff) ? h_cnt : h_cnt + 12'd1;
    v_inc    = (v_cnt == 11'h7ff) ? v_cnt : v_cnt + 11'd1;
    h_next   = hs_rise ? 12'd0 : h_inc;
    v_next   = v_cnt;
    if (vs_rise) begin
      v_next = 11'd0;
    end else if (hs_rise) begin
      v_next = v_inc;
    end
    active   = (h_next >= h_start) && (h_next < h_period) &&
               (v_next >= v_start) && (v_next < v_period);
    // A line is bad if it ends at the wrong length or runs past the period without an edge
    line_err  = hs_rise ? (h_inc != h_period) : (h_inc == h_period);
    frame_err = vs_rise ? (v_inc != v_period) : (hs_rise && (v_inc == v_period));
    err       = (state != st_search) && (line_err || frame_err);
    good_inc  = (good_cnt == 4'hf) ? good_cnt : good_cnt + 4'd1;
  end

  // Stage 2: counters, measured lengths and the registered pixel outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= 12'd0;
      v_cnt       <= 11'd0;
      line_len    <= 12'd0;
      frame_lines <= 11'd0;
      pix_x       <= 11'd0;
      pix_y       <= 10'd0;
      pix_valid   <= 1'b0;
      pix_rgb     <= 3'd0;
    end else begin
      h_cnt <= h_next;
      v_cnt <= v_next;
      if (hs_rise) begin
        line_len <= h_inc;
      end
      if (vs_rise) begin
        frame_lines <= v_inc;
      end
      pix_valid <= active;
      pix_x     <= active ? (h_next[10:0] - h_start_x) : 11'd0;
      pix_y     <= active ? (v_next[9:0] - v_start_y) : 10'd0;
      pix_rgb   <= active ? rgb_q : 3'd0;
    end
  end

  // Lock FSM: first vsync starts tracking, enough clean frames lock, any violation drops to search
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= st_search;
      good_cnt   <= 4'd0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      case (state)
        st_search: begin
          if (vs_rise) begin
            state    <= st_track;
            good_cnt <= 4'd0;
          end
        end
        st_track, st_locked: begin
          if (err) begin
            timing_err <= 1'b1;
            locked     <= 1'b0;
            good_cnt   <= 4'd0;
            state      <= st_search;
          end else if (vs_rise) begin
            good_cnt <= good_inc;
            if (good_inc >= lock_target) begin
              state  <= st_locked;
              locked <= 1'b1;
            end
          end
        end
        default: begin
          state    <= st_search;
          good_cnt <= 4'd0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver
// Directed bench for vga_sync_receiver in a reduced mode so that whole frames
// are cheap: 24-clock lines (sync 4, porch 4, active 16) and 14-line frames
// (sync 1, porch 3, active 10). Active pixels start at h_cnt 8 and line 4.
module tb_vga_sync_receiver;

  localparam int h_len   = 24;
  localparam int n_lines = 14;
  localparam int hs_w    = 4;

  logic        clk;
  logic        reset;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid;
  logic [2:0]  pix_rgb;
  logic [11:0] line_len;
  logic [10:0] frame_lines;
  logic        locked;
  logic        timing_err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Hand-computed expected pixels: {pix_valid, pix_x[10:0], pix_y[9:0], pix_rgb[2:0]}
  logic [24:0] exp_q[$];

  vga_sync_receiver #(
    .h_size(16), .h_synctime(4), .h_porch(4),
    .v_size(10), .v_synctime(1), .v_porch(3),
    .lock_frames(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_valid(pix_valid),
    .pix_rgb(pix_rgb),
    .line_len(line_len),
    .frame_lines(frame_lines),
    .locked(locked),
    .timing_err(timing_err),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout got running expected finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one input sample; returns 1 time unit after the edge that captured it
  task automatic drive(input logic hs, input logic vs, input logic [2:0] c);
    hsync = hs;
    vsync = vs;
    rgb   = c;
    @(posedge clk);
    #1;
  endtask

  // Drive columns x0..x1-1 of a line; rgb pattern is (x+5) mod 8
  task automatic line_part(input int x0, input int x1, input logic vs_on, input logic hs_on);
    for (int x = x0; x < x1; x++) begin
      drive(hs_on && (x < hs_w), vs_on, 3'(x + 5));
    end
  endtask

  task automatic lines(input int l0, input int l1);
    for (int l = l0; l < l1; l++) begin
      line_part(0, h_len, (l == 0), 1'b1);
    end
  endtask

  // Full nominal frame; lock is checked two samples after the vsync edge
  task automatic start_frame(input logic exp_lock);
    line_part(0, 2, 1'b1, 1'b1);
    check_eq("lock_after_vsync", 64'(locked), 64'(exp_lock));
    line_part(2, h_len, 1'b1, 1'b1);
    lines(1, n_lines);
  endtask

  task automatic check_pix(input string tag);
    logic [24:0] exp;
    exp = exp_q.pop_front();
    check_eq(tag, 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'(exp));
  endtask

  // Drive line l and check the outputs for samples x=7, x=8 and x=22
  task automatic probe_line(input int l);
    line_part(0, 9, (l == 0), 1'b1);
    check_pix("pix_x7");
    line_part(9, 10, (l == 0), 1'b1);
    check_pix("pix_x8");
    line_part(10, 24, (l == 0), 1'b1);
    check_pix("pix_x22");
  endtask

  int pulses;
  int first_pulse;

  initial begin
    reset = 1'b1;
    hsync = 1'b0;
    vsync = 1'b0;
    rgb   = 3'd0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    check_eq("reset_pix", 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'd0);
    check_eq("reset_status", 64'({line_len, frame_lines, locked, timing_err, state_dbg}), 64'd0);
    reset = 1'b0;

    // Lock acquisition: vsync 1 -> track, vsync 2 -> one good frame, vsync 3 -> locked
    start_frame(1'b0);
    check_eq("track_state", 64'(state_dbg), 64'd1);
    start_frame(1'b0);
    line_part(0, 1, 1'b1, 1'b1);
    check_eq("lock_one_cycle", 64'(locked), 64'd0);
    line_part(1, 2, 1'b1, 1'b1);
    check_eq("lock_two_cycles", 64'(locked), 64'd1);
    check_eq("locked_state", 64'(state_dbg), 64'd2);
    check_eq("frame_lines_nom", 64'(frame_lines), 64'd14);
    check_eq("line_len_nom", 64'(line_len), 64'd24);
    line_part(2, h_len, 1'b1, 1'b1);

    // Pixel recovery in frame 3
    exp_q.push_back({1'b0, 11'd0, 10'd0, 3'd0});
    exp_q.push_back({1'b0, 11'd0, 10'd0, 3'd0});
    exp_q.push_back({1'b0, 11'd0, 10'd0, 3'd0});
    probe_line(1);
    lines(2, 4);
    exp_q.push_back({1'b0, 11'd0, 10'd0, 3'd0});
    exp_q.push_back({1'b1, 11'd0, 10'd0, 3'b101});
    exp_q.push_back({1'b1, 11'd14, 10'd0, 3'b011});
    probe_line(4);
    lines(5, 13);
    exp_q.push_back({1'b0, 11'd0, 10'd0, 3'd0});
    exp_q.push_back({1'b1, 11'd0, 10'd9, 3'b101});
    exp_q.push_back({1'b1, 11'd14, 10'd9, 3'b011});
    probe_line(13);
    check_eq("still_locked", 64'(locked), 64'd1);

    // Short line (23 clocks) in frame 4
    lines(0, 1);
    line_part(0, 23, 1'b0, 1'b1);
    line_part(0, 1, 1'b0, 1'b1);
    check_eq("short_no_err_yet", 64'(timing_err), 64'd0);
    line_part(1, 2, 1'b0, 1'b1);
    check_eq("short_err", 64'(timing_err), 64'd1);
    check_eq("short_unlock", 64'(locked), 64'd0);
    check_eq("short_line_len", 64'(line_len), 64'd23);
    check_eq("short_search", 64'(state_dbg), 64'd0);
    line_part(2, 3, 1'b0, 1'b1);
    check_eq("short_err_pulse", 64'(timing_err), 64'd0);
    line_part(3, h_len, 1'b0, 1'b1);
    lines(3, n_lines);
    start_frame(1'b0);
    start_frame(1'b0);
    start_frame(1'b1);

    // hsync held low in frame 8
    lines(0, 2);
    pulses      = 0;
    first_pulse = -1;
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0);
      if (timing_err) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    check_eq("nohs_pulses", 64'(pulses), 64'd1);
    check_eq("nohs_pulse_at", 64'(first_pulse), 64'd1);
    check_eq("nohs_unlock", 64'(locked), 64'd0);
    lines(3, n_lines);
    start_frame(1'b0);
    start_frame(1'b0);
    start_frame(1'b1);

    // Frame of 13 lines, error flagged at the next vsync
    lines(0, 13);
    line_part(0, 2, 1'b1, 1'b1);
    check_eq("short_frame_err", 64'(timing_err), 64'd1);
    check_eq("short_frame_lines", 64'(frame_lines), 64'd13);
    check_eq("short_frame_unlock", 64'(locked), 64'd0);
    line_part(2, h_len, 1'b1, 1'b1);
    lines(1, n_lines);
    start_frame(1'b0);
    start_frame(1'b0);
    start_frame(1'b1);

    // One-cycle reset mid-frame while locked
    lines(0, 5);
    line_part(0, 10, 1'b0, 1'b1);
    check_eq("pre_reset_valid", 64'(pix_valid), 64'd1);
    reset = 1'b1;
    line_part(10, 11, 1'b0, 1'b1);
    reset = 1'b0;
    check_eq("midreset_pix", 64'({pix_valid, pix_x, pix_y, pix_rgb}), 64'd0);
    check_eq("midreset_status", 64'({line_len, frame_lines, locked, timing_err, state_dbg}), 64'd0);
    line_part(11, h_len, 1'b0, 1'b1);
    lines(6, n_lines);
    start_frame(1'b0);
    start_frame(1'b0);
    start_frame(1'b1);
    check_eq("relock_final", 64'(locked), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
